// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl
//   Receive-side controller between the host register interface and the UART
//   receiver. Holds the receiver configuration (parity enable/type, prescaler)
//   and only applies host updates while the line is idle between frames.
//   Tracks frame/break occupancy on the serial line and buffers received
//   bytes in a show-ahead FIFO with sticky overrun detection.
//
// Ports
//   CLK, RST              clock, asynchronous active-high reset
//   RX_IN                 synchronised serial line (occupancy tracking only)
//   CFG_WR/CFG_PAR_EN/CFG_PAR_TYP/CFG_PRESCALE   host config write
//   CFG_ACK, CFG_ERR      one-cycle pulses: config applied / write rejected
//   PAR_EN, PAR_TYP, Prescaler                   active receiver config
//   BUSY                  frame or break in progress
//   RX_P_DATA, RX_DATA_VALID                     byte strobe from receiver
//   RD_EN, RD_DATA        pop / head of FIFO (0 when empty)
//   FIFO_EMPTY, FIFO_FULL FIFO status
//   OVERRUN, OVR_CLR      sticky byte-dropped flag and its clear
module uart_rx_ctrl #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DATA_WD    = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               RX_IN,
  input  logic               CFG_WR,
  input  logic               CFG_PAR_EN,
  input  logic               CFG_PAR_TYP,
  input  logic [4:0]         CFG_PRESCALE,
  output logic               CFG_ACK,
  output logic               CFG_ERR,
  output logic               PAR_EN,
  output logic               PAR_TYP,
  output logic [4:0]         Prescaler,
  output logic               BUSY,
  input  logic [DATA_WD-1:0] RX_P_DATA,
  input  logic               RX_DATA_VALID,
  input  logic               RD_EN,
  output logic [DATA_WD-1:0] RD_DATA,
  output logic               FIFO_EMPTY,
  output logic               FIFO_FULL,
  output logic               OVERRUN,
  input  logic               OVR_CLR
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FRAME = 2'd1,
    BREAK = 2'd2
  } line_state_t;

  line_state_t state, state_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic        rx_q;
  logic        fall;
  logic [7:0]  frame_bits;
  logic [7:0]  frame_len;

  // ---------------- line occupancy FSM ----------------
  assign fall       = rx_q & ~RX_IN;
  assign frame_bits = PAR_EN ? 8'd11 : 8'd10;
  // Largest value is 11*16-1 = 175, so 8 bits never overflow.
  assign frame_len  = frame_bits * {3'b000, Prescaler} - 8'd1;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      cnt   <= '0;
      rx_q  <= 1'b1;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      rx_q  <= RX_IN;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (fall) begin
          state_nxt = FRAME;
          cnt_nxt   = frame_len;
        end
      end
      FRAME: begin
        if (cnt == 8'd0) state_nxt = RX_IN ? IDLE : BREAK;
        else             cnt_nxt   = cnt - 8'd1;
      end
      BREAK: begin
        if (RX_IN) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign BUSY = (state != IDLE);

  // ---------------- configuration ----------------
  logic       cfg_legal;
  logic       pend;
  logic       pend_par_en;
  logic       pend_par_typ;
  logic [4:0] pend_prescale;
  logic       apply;

  assign cfg_legal = (CFG_PRESCALE == 5'd8) || (CFG_PRESCALE == 5'd16);
  // RX_IN high guarantees no start edge is being taken this cycle.
  assign apply     = pend && (state == IDLE) && RX_IN;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pend          <= 1'b0;
      pend_par_en   <= 1'b0;
      pend_par_typ  <= 1'b0;
      pend_prescale <= 5'd8;
      PAR_EN        <= 1'b0;
      PAR_TYP       <= 1'b0;
      Prescaler     <= 5'd8;
      CFG_ACK       <= 1'b0;
      CFG_ERR       <= 1'b0;
    end else begin
      CFG_ACK <= apply;
      CFG_ERR <= CFG_WR && !cfg_legal;
      if (apply) begin
        PAR_EN    <= pend_par_en;
        PAR_TYP   <= pend_par_typ;
        Prescaler <= pend_prescale;
      end
      // A write coinciding with an apply survives as the next pending set.
      if (CFG_WR && cfg_legal) begin
        pend          <= 1'b1;
        pend_par_en   <= CFG_PAR_EN;
        pend_par_typ  <= CFG_PAR_TYP;
        pend_prescale <= CFG_PRESCALE;
      end else if (apply) begin
        pend <= 1'b0;
      end
    end
  end

  // ---------------- receive FIFO ----------------
  logic [DATA_WD-1:0] mem [FIFO_DEPTH];
  logic [AW:0]        wr_ptr, rd_ptr;
  logic               push, pop, drop;

  assign FIFO_EMPTY = (wr_ptr == rd_ptr);
  assign FIFO_FULL  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop        = RD_EN && !FIFO_EMPTY;
  // When full, a simultaneous pop frees the slot the push writes into.
  assign push       = RX_DATA_VALID && (!FIFO_FULL || RD_EN);
  assign drop       = RX_DATA_VALID && FIFO_FULL && !RD_EN;
  assign RD_DATA    = FIFO_EMPTY ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr[AW-1:0]] <= RX_P_DATA;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      OVERRUN <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (drop)         OVERRUN <= 1'b1;
      else if (OVR_CLR) OVERRUN <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl
//   Directed bench for uart_rx_ctrl: reset values, config apply timing,
//   rejected writes, frame/break occupancy, FIFO fill/drain/overrun and an
//   asynchronous reset taken mid-frame.
module tb_uart_rx_ctrl;

  logic       CLK_TB;
  logic       rst;
  logic       rx_in;
  logic       cfg_wr, cfg_par_en, cfg_par_typ;
  logic [4:0] cfg_prescale;
  logic       cfg_ack, cfg_err, par_en, par_typ;
  logic [4:0] prescaler;
  logic       busy;
  logic [7:0] rx_p_data;
  logic       rx_data_valid, rd_en;
  logic [7:0] rd_data;
  logic       fifo_empty, fifo_full, overrun, ovr_clr;

  int unsigned errs   = 0;
  int unsigned checks = 0;

  uart_rx_ctrl #(.FIFO_DEPTH(4), .DATA_WD(8)) dut (
    .CLK          (CLK_TB),
    .RST          (rst),
    .RX_IN        (rx_in),
    .CFG_WR       (cfg_wr),
    .CFG_PAR_EN   (cfg_par_en),
    .CFG_PAR_TYP  (cfg_par_typ),
    .CFG_PRESCALE (cfg_prescale),
    .CFG_ACK      (cfg_ack),
    .CFG_ERR      (cfg_err),
    .PAR_EN       (par_en),
    .PAR_TYP      (par_typ),
    .Prescaler    (prescaler),
    .BUSY         (busy),
    .RX_P_DATA    (rx_p_data),
    .RX_DATA_VALID(rx_data_valid),
    .RD_EN        (rd_en),
    .RD_DATA      (rd_data),
    .FIFO_EMPTY   (fifo_empty),
    .FIFO_FULL    (fifo_full),
    .OVERRUN      (overrun),
    .OVR_CLR      (ovr_clr)
  );

  initial CLK_TB = 1'b0;
  always #5 CLK_TB = ~CLK_TB;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge CLK_TB);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    rx_p_data     = b;
    rx_data_valid = 1'b1;
    tick();
    rx_data_valid = 1'b0;
  endtask

  logic [7:0] vec [5];
  int unsigned busy_cnt, ack_cnt, ack_idx, err_cnt;

  initial begin
    vec[0] = 8'hA5; vec[1] = 8'h3C; vec[2] = 8'h0F; vec[3] = 8'hF0; vec[4] = 8'h77;
    rst = 1'b1; rx_in = 1'b1; cfg_wr = 1'b0; cfg_par_en = 1'b0; cfg_par_typ = 1'b0;
    cfg_prescale = 5'd8; rx_p_data = '0; rx_data_valid = 1'b0; rd_en = 1'b0; ovr_clr = 1'b0;
    repeat (3) tick();

    // reset values
    chk("rst_prescaler", prescaler, 8);
    chk("rst_par_en", par_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_empty", fifo_empty, 1);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_overrun", overrun, 0);
    rst = 1'b0;
    repeat (2) tick();

    // frame at prescale 8, no parity (L=80); config written mid-frame
    rx_in = 1'b0;
    tick();
    busy_cnt = 0; ack_cnt = 0; ack_idx = 0;
    for (int i = 0; i < 200; i++) begin
      if (busy) busy_cnt++;
      if (cfg_ack) begin ack_cnt++; ack_idx = i; end
      if (i == 0) rx_in = 1'b1;
      if (i == 19) begin
        cfg_wr = 1'b1; cfg_par_en = 1'b1; cfg_par_typ = 1'b1; cfg_prescale = 5'd16;
      end
      if (i == 20) cfg_wr = 1'b0;
      tick();
    end
    chk("frame_busy_len", busy_cnt, 80);
    chk("frame_ack_count", ack_cnt, 1);
    chk("frame_ack_pos", ack_idx, 81);
    chk("frame_cfg_par_en", par_en, 1);
    chk("frame_cfg_par_typ", par_typ, 1);
    chk("frame_cfg_prescale", prescaler, 16);

    // idle config write: ack one cycle later
    cfg_wr = 1'b1; cfg_par_en = 1'b1; cfg_par_typ = 1'b0; cfg_prescale = 5'd8;
    tick();
    cfg_wr = 1'b0;
    chk("idle_no_early_ack", cfg_ack, 0);
    tick();
    chk("idle_ack", cfg_ack, 1);
    chk("idle_par_en", par_en, 1);
    chk("idle_par_typ", par_typ, 0);
    chk("idle_prescale", prescaler, 8);
    tick();
    chk("idle_ack_pulse", cfg_ack, 0);

    // illegal prescale
    cfg_wr = 1'b1; cfg_par_en = 1'b0; cfg_par_typ = 1'b1; cfg_prescale = 5'd5;
    tick();
    cfg_wr = 1'b0;
    chk("bad_err", cfg_err, 1);
    chk("bad_no_ack0", cfg_ack, 0);
    tick();
    chk("bad_err_pulse", cfg_err, 0);
    chk("bad_no_ack1", cfg_ack, 0);
    tick();
    chk("bad_no_ack2", cfg_ack, 0);
    chk("bad_par_en", par_en, 1);
    chk("bad_par_typ", par_typ, 0);
    chk("bad_prescale", prescaler, 8);

    // break: line low 200 cycles, config pending throughout
    rx_in = 1'b0;
    tick();
    busy_cnt = 0; ack_cnt = 0; err_cnt = 0;
    for (int i = 0; i < 200; i++) begin
      if (busy) busy_cnt++;
      if (cfg_ack) ack_cnt++;
      if (cfg_err) err_cnt++;
      if (i == 1) begin
        cfg_wr = 1'b1; cfg_par_en = 1'b0; cfg_par_typ = 1'b0; cfg_prescale = 5'd16;
      end
      if (i == 2) cfg_wr = 1'b0;
      tick();
    end
    chk("break_busy", busy_cnt, 200);
    chk("break_no_ack", ack_cnt, 0);
    chk("break_no_err", err_cnt, 0);
    rx_in = 1'b1;
    tick();
    chk("break_end_idle", busy, 0);
    chk("break_end_no_ack", cfg_ack, 0);
    tick();
    chk("break_ack", cfg_ack, 1);
    chk("break_prescale", prescaler, 16);
    chk("break_par_en", par_en, 0);

    // FIFO fill, overrun, drain
    for (int k = 0; k < 5; k++) begin
      push_byte(vec[k]);
      if (k == 0) begin
        chk("fifo_not_empty", fifo_empty, 0);
        chk("fifo_head_first", rd_data, 8'hA5);
      end
      if (k == 2) chk("fifo_not_full3", fifo_full, 0);
      if (k == 3) begin
        chk("fifo_full4", fifo_full, 1);
        chk("fifo_no_ovr4", overrun, 0);
      end
      if (k == 4) begin
        chk("fifo_ovr5", overrun, 1);
        chk("fifo_head_kept", rd_data, 8'hA5);
      end
    end
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("fifo_rd%0d", k), rd_data, vec[k]);
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
    end
    chk("fifo_drained_empty", fifo_empty, 1);
    chk("fifo_drained_data", rd_data, 0);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("fifo_pop_empty_ignored", fifo_empty, 1);
    chk("fifo_pop_empty_full", fifo_full, 0);
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    chk("fifo_ovr_clr", overrun, 0);

    // push+pop on full, then overrun racing OVR_CLR
    for (int k = 1; k <= 4; k++) push_byte(8'(k));
    chk("fifo_refull", fifo_full, 1);
    rd_en = 1'b1;
    push_byte(8'h05);
    rd_en = 1'b0;
    chk("fifo_pushpop_no_ovr", overrun, 0);
    chk("fifo_pushpop_full", fifo_full, 1);
    chk("fifo_pushpop_head", rd_data, 8'h02);
    ovr_clr = 1'b1;
    push_byte(8'h06);
    ovr_clr = 1'b0;
    chk("fifo_ovr_wins_clr", overrun, 1);
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    chk("fifo_ovr_clr2", overrun, 0);
    rd_en = 1'b1;
    tick();
    tick();
    rd_en = 1'b0;
    chk("fifo_two_left_head", rd_data, 8'h04);
    ovr_clr = 1'b1;
    push_byte(8'h99);
    rx_p_data = 8'h00;
    ovr_clr = 1'b0;
    // provoke a sticky overrun bit before reset: fill to full then drop one
    push_byte(8'h98);
    push_byte(8'h97);
    chk("pre_rst_ovr", overrun, 1);

    // asynchronous reset mid-frame with bytes buffered
    rx_in = 1'b0;
    tick();
    chk("pre_rst_busy", busy, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_empty", fifo_empty, 1);
    chk("async_rst_full", fifo_full, 0);
    chk("async_rst_rd_data", rd_data, 0);
    chk("async_rst_overrun", overrun, 0);
    chk("async_rst_prescale", prescaler, 8);
    chk("async_rst_par_en", par_en, 0);
    chk("async_rst_par_typ", par_typ, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
